// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, default baud timing and stop-bit options.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_HZ       = 100_000_000;
  localparam int unsigned DEFAULT_BAUD         = 115_200;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = DEFAULT_CLK_HZ / DEFAULT_BAUD;

  localparam int unsigned STOP_BITS_ONE = 1;
  localparam int unsigned STOP_BITS_TWO = 2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by the UART TX and RX paths: counts 0..CLKS_PER_BIT-1
// and flags the last clk of each bit period. Held at zero while clear is high.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             bit_end
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  assign bit_end = !clear && (count == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: pops bytes from the TX FIFO and serialises them LSB first (8N1 by default).
// Define UART_TX_PARITY_EN to add a parity bit between the data and stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = STOP_BITS_ONE,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] DATA_LAST    = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST    = IDX_W'(STOP_BITS - 1);

  uart_tx_state_t        state, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  bit_end;
  logic                  timer_clear;
  logic                  tx_d, rd_en_d, busy_d, done_d;

  // The timer is held at zero until START, so the start bit gets a full period.
  assign timer_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .count  (bit_cnt),
    .bit_end(bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (state == LOAD) begin
      parity_q <= (^fifo_rd_data) ^ (PARITY_ODD != 0);
    end
  end
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state;
    shift_d = shift_q;
    idx_d   = idx_q;

    unique case (state)
      IDLE:  if (!fifo_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_rd_data;
        idx_d   = '0;
        state_d = START;
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == DATA_LAST) begin
            // idx is reused to count stop bits from here on.
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = fifo_empty ? IDLE : FETCH;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they change with the state.
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase

    rd_en_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);
    done_d  = (state == STOP) && (bit_cnt == CNT_PRE_LAST) && (idx_q == STOP_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state      <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tx         <= tx_d;
      fifo_rd_en <= rd_en_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at CLKS_PER_BIT=4: three instances (1 stop/even,
// 2 stop/even, 1 stop/odd) each fed by a small FIFO model.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN  = (1 + 8 + PAR + 1) * CPB;
  localparam int FLEN2 = (1 + 8 + PAR + 2) * CPB;

  logic clk;
  logic reset;

  logic [2:0] empty_v;
  logic [2:0] rd_v;
  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] fd_v;
  logic [7:0] rd_data_v [3] = '{default: 8'h00};
  logic [7:0] mem [3][16];
  int         wr_cnt [3] = '{0, 0, 0};
  int         rd_ptr [3] = '{0, 0, 0};

  int n_assert = 0;
  int n_fail   = 0;

  logic [255:0] trace;
  logic [255:0] busy_tr;
  logic [255:0] exp_w;
  int           exp_len;
  int           rd_cnt, fd_cnt, fd_first, fd_last, start_pos, tx_low, busy_hi;

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .fifo_empty(empty_v[0]), .fifo_rd_data(rd_data_v[0]),
    .fifo_rd_en(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(empty_v[1]), .fifo_rd_data(rd_data_v[1]),
    .fifo_rd_en(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));

  uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .fifo_empty(empty_v[2]), .fifo_rd_data(rd_data_v[2]),
    .fifo_rd_en(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after the pop.
  always_comb begin
    for (int k = 0; k < 3; k++) empty_v[k] = (rd_ptr[k] == wr_cnt[k]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd_v[k]) begin
        rd_data_v[k] <= mem[k][rd_ptr[k] % 16];
        rd_ptr[k]    <= rd_ptr[k] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    mem[sel][wr_cnt[sel] % 16] = d;
    wr_cnt[sel]++;
  endtask

  task automatic capture(input int sel, input int ncyc);
    trace = '1; busy_tr = '0;
    rd_cnt = 0; fd_cnt = 0; fd_first = -1; fd_last = -1;
    start_pos = -1; tx_low = 0; busy_hi = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      trace[i]   = tx_v[sel];
      busy_tr[i] = busy_v[sel];
      if (!tx_v[sel]) begin
        tx_low++;
        if (start_pos < 0) start_pos = i;
      end
      if (busy_v[sel]) busy_hi++;
      if (rd_v[sel]) rd_cnt++;
      if (fd_v[sel]) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = i;
        fd_last = i;
      end
    end
  endtask

  task automatic clear_exp();
    exp_w = '0;
    exp_len = 0;
  endtask

  task automatic add_level(input logic b, input int cycles);
    for (int j = 0; j < cycles; j++) begin
      exp_w[exp_len] = b;
      exp_len++;
    end
  endtask

  task automatic add_frame(input logic [7:0] d, input int stop_bits, input logic odd);
    add_level(1'b0, CPB);
    for (int k = 0; k < 8; k++) add_level(d[k], CPB);
    if (PAR == 1) add_level((^d) ^ odd, CPB);
    add_level(1'b1, stop_bits * CPB);
  endtask

  task automatic check_wave(input string tag);
    logic [255:0] obs;
    obs = '0;
    for (int k = 0; k < exp_len; k++) begin
      obs[k] = (start_pos >= 0 && start_pos + k < 256) ? trace[start_pos + k] : 1'bx;
    end
    check(tag, obs, exp_w);
  endtask

  // Samples the centre of each of the first nbits bit periods after start.
  function automatic logic [15:0] centres(input int nbits);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < nbits; k++) begin
      v[k] = (start_pos >= 0) ? trace[start_pos + k * CPB + 2] : 1'bx;
    end
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx_v[0], 1);
    check("reset_rd_en", rd_v[0], 0);
    check("reset_busy", busy_v[0], 0);
    check("reset_frame_done", fd_v[0], 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5.
    push(0, 8'hA5);
    capture(0, FLEN + 8);
    check("a5_latency", start_pos, 2);
    check("a5_centres", centres(9), 16'h014A);
    clear_exp(); add_frame(8'hA5, 1, 1'b0);
    check_wave("a5_wave");
    check("a5_pops", rd_cnt, 1);
    check("a5_done_count", fd_cnt, 1);
    check("a5_done_pos", fd_first - start_pos, FLEN - 1);
    check("a5_busy_first", busy_tr[0], 1);
    check("a5_idle_after", busy_tr[start_pos + FLEN], 0);

    // Back-to-back 0x00 then 0xFF.
    @(negedge clk);
    push(0, 8'h00);
    push(0, 8'hFF);
    capture(0, 2 * FLEN + 12);
    clear_exp(); add_frame(8'h00, 1, 1'b0); add_level(1'b1, 2); add_frame(8'hFF, 1, 1'b0);
    check_wave("b2b_wave");
    check("b2b_pops", rd_cnt, 2);
    check("b2b_done_count", fd_cnt, 2);
    check("b2b_done_spacing", fd_last - fd_first, FLEN + 2);
    check("b2b_busy_gap", busy_tr[start_pos + FLEN], 1);

    // Empty FIFO for 100 clk.
    capture(0, 100);
    check("empty_tx_low", tx_low, 0);
    check("empty_pops", rd_cnt, 0);
    check("empty_busy", busy_hi, 0);

    // Reset during DATA bit 3 of 0x30 (bit 3 is 0).
    @(negedge clk);
    push(0, 8'h30);
    for (int i = 0; i < 20; i++) @(negedge clk);
    check("mid_pre_bit3", tx_v[0], 0);
    reset = 1'b0;
    #1;
    check("mid_reset_tx", tx_v[0], 1);
    check("mid_reset_busy", busy_v[0], 0);
    check("mid_reset_rd_en", rd_v[0], 0);
    @(negedge clk);
    reset = 1'b1;
    capture(0, 30);
    check("mid_after_pops", rd_cnt, 0);
    check("mid_after_tx_low", tx_low, 0);
    check("mid_after_busy", busy_hi, 0);

    // Byte 0x07 with even parity configuration.
    push(0, 8'h07);
    capture(0, FLEN + 8);
    clear_exp(); add_frame(8'h07, 1, 1'b0);
    check_wave("p07_even_wave");
    check("p07_even_len", fd_first - start_pos, FLEN - 1);
`ifdef UART_TX_PARITY_EN
    check("p07_even_parity", trace[start_pos + 9 * CPB + 2], 1);
`endif

    // Byte 0x07 with odd parity configuration (ignored without parity).
    push(2, 8'h07);
    capture(2, FLEN + 8);
    clear_exp(); add_frame(8'h07, 1, 1'b1);
    check_wave("p07_odd_wave");
    check("p07_odd_len", fd_first - start_pos, FLEN - 1);
`ifdef UART_TX_PARITY_EN
    check("p07_odd_parity", trace[start_pos + 9 * CPB + 2], 0);
`endif

    // Two stop bits, byte 0x3C.
    push(1, 8'h3C);
    capture(1, FLEN2 + 8);
    check("sb2_latency", start_pos, 2);
    clear_exp(); add_frame(8'h3C, 2, 1'b0);
    check_wave("sb2_wave");
    check("sb2_done_pos", fd_first - start_pos, FLEN2 - 1);
    check("sb2_done_count", fd_cnt, 1);
    check("sb2_idle_after", busy_tr[start_pos + FLEN2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
